// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter only has to reach width-1, so $clog2 suffices (never below 1 bit).
   function automatic int cnt_width(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input  in_ready, out_valid, sum, cout);
   modport slave  (input  in_valid, a, b, cin, out_ready,
                   output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/serial_adder_fa_cell.sv
// Combinational full-adder cell built from two half-adder stages and a carry OR.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic ha0_sum_s;
   logic ha0_carry_s;
   logic ha1_carry_s;

   assign ha0_sum_s   = a ^ b;
   assign ha0_carry_s = a & b;
   assign sum         = ha0_sum_s ^ cin;
   assign ha1_carry_s = ha0_sum_s & cin;
   assign cout        = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a carry flop, WIDTH cycles per add.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int             CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_sh_r;
   logic             c_r;
   logic [CW-1:0]    cnt_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             s_s;
   logic             c_next_s;
   logic             accept_s;
   logic             last_s;

   fa_cell u_fa (
      .a    (a_sh_r[0]),
      .b    (b_sh_r[0]),
      .cin  (c_r),
      .sum  (s_s),
      .cout (c_next_s)
   );

   // Next-state decode; DONE never accepts new operands, even when draining.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      last_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.in_valid) begin
               accept_s = 1'b1;
               state_s  = SHIFT;
            end else begin
               state_s  = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == LAST) begin
               last_s  = 1'b1;
               state_s = DONE;
            end else begin
               state_s = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register and handshake flags, derived from the next state so they stay registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == DONE);
      end
   end

   // Shift datapath, carry flop, bit counter and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         sum_sh_r <= '0;
         c_r      <= 1'b0;
         cnt_r    <= '0;
         sum_r    <= '0;
         cout_r   <= 1'b0;
      end else if (accept_s) begin
         a_sh_r   <= bus.a;
         b_sh_r   <= bus.b;
         sum_sh_r <= '0;
         c_r      <= bus.cin;
         cnt_r    <= '0;
      end else if (state_r == SHIFT) begin
         a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
         sum_sh_r <= {s_s, sum_sh_r[WIDTH-1:1]};
         c_r      <= c_next_s;
         if (last_s) begin
            cnt_r  <= '0;
            sum_r  <= {s_s, sum_sh_r[WIDTH-1:1]};
            cout_r <= c_next_s;
         end else begin
            cnt_r  <= cnt_r + CW'(1'b1);
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_r;

   // On the last bit c_r is the carry into the MSB and c_next_s the carry out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (last_s) begin
         ovf_r <= c_r ^ c_next_s;
      end
   end

   assign bus.ovf = ovf_r;
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 (vector table + scoreboard).
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(8))  bus8 ();
   serial_adder_if #(.WIDTH(16)) bus16 ();

   serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
   serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

   int n_tests = 0;
   int n_fail  = 0;
   int n_out8  = 0;
   int n_out16 = 0;
   bit rnd_en  = 1'b0;

   logic [8:0]  q8[$];
   logic [16:0] q16[$];
   logic [8:0]  e8;
   logic [16:0] e16;
`ifdef SERIAL_ADDER_OVF_EN
   logic q8o[$];
   logic q16o[$];
   logic eo8;
   logic eo16;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got unexpected event expected none", name);
   endtask

   // Scoreboard for the 8-bit instance: push on input handshake, pop on output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus8.in_valid && bus8.in_ready) begin
            q8.push_back({1'b0, bus8.a} + {1'b0, bus8.b} + {8'd0, bus8.cin});
`ifdef SERIAL_ADDER_OVF_EN
            q8o.push_back((bus8.a[7] == bus8.b[7]) &&
                          (((bus8.a + bus8.b + {7'd0, bus8.cin}) >> 7) != {7'd0, bus8.a[7]}));
`endif
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (q8.size() == 0) begin
               fail_now("sb8_extra_result");
            end else begin
               e8 = q8.pop_front();
               check("sb8_sum", 64'(bus8.sum), 64'(e8[7:0]));
               check("sb8_cout", 64'(bus8.cout), 64'(e8[8]));
`ifdef SERIAL_ADDER_OVF_EN
               eo8 = q8o.pop_front();
               check("sb8_ovf", 64'(bus8.ovf), 64'(eo8));
`endif
               n_out8++;
            end
         end
      end
   end

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus16.in_valid && bus16.in_ready) begin
            q16.push_back({1'b0, bus16.a} + {1'b0, bus16.b} + {16'd0, bus16.cin});
`ifdef SERIAL_ADDER_OVF_EN
            q16o.push_back((bus16.a[15] == bus16.b[15]) &&
                           (((bus16.a + bus16.b + {15'd0, bus16.cin}) >> 15) != {15'd0, bus16.a[15]}));
`endif
         end
         if (bus16.out_valid && bus16.out_ready) begin
            if (q16.size() == 0) begin
               fail_now("sb16_extra_result");
            end else begin
               e16 = q16.pop_front();
               check("sb16_sum", 64'(bus16.sum), 64'(e16[15:0]));
               check("sb16_cout", 64'(bus16.cout), 64'(e16[16]));
`ifdef SERIAL_ADDER_OVF_EN
               eo16 = q16o.pop_front();
               check("sb16_ovf", 64'(bus16.ovf), 64'(eo16));
`endif
               n_out16++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_en) begin
         bus8.out_ready  = ($urandom_range(0, 3) != 0);
         bus16.out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Present operands and hold in_valid until the edge that accepts them.
   task automatic send(input bit w16, input logic [15:0] a, input logic [15:0] b, input logic cin);
      logic rdy;
      int   g;
      g = 0;
      if (w16) begin
         bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.in_valid = 1'b1;
      end else begin
         bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin; bus8.in_valid = 1'b1;
      end
      do begin
         rdy = w16 ? bus16.in_ready : bus8.in_ready;
         tick();
         g++;
      end while (!rdy && g < 100);
      bus8.in_valid  = 1'b0;
      bus16.in_valid = 1'b0;
      if (!rdy) fail_now("accept_timeout");
   endtask

   // Count cycles after the accept edge until out_valid (accept cycle is cycle 0).
   task automatic wait_out8(output int k);
      k = 1;
      while (!bus8.out_valid && k < 100) begin
         tick();
         k++;
      end
   endtask

   initial begin
      vec_t vt[4];
      int   k;
      int   base;
      int   g;

      vt[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[2] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1};
      vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

      rst = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.out_ready  = 1'b1;
      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
      check("rst_sum", 64'(bus8.sum), 64'd0);
      check("rst_cout", 64'(bus8.cout), 64'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         send(1'b0, {8'd0, vt[i].a}, {8'd0, vt[i].b}, vt[i].cin);
         wait_out8(k);
         check($sformatf("vec%0d_latency", i), 64'(k), 64'd9);
         check($sformatf("vec%0d_sum", i), 64'(bus8.sum), 64'(vt[i].sum));
         check($sformatf("vec%0d_cout", i), 64'(bus8.cout), 64'(vt[i].cout));
`ifdef SERIAL_ADDER_OVF_EN
         check($sformatf("vec%0d_ovf", i), 64'(bus8.ovf), 64'(vt[i].ovf));
`endif
         tick();
         check($sformatf("vec%0d_in_ready_after", i), 64'(bus8.in_ready), 64'd1);
         check($sformatf("vec%0d_out_valid_after", i), 64'(bus8.out_valid), 64'd0);
      end

      // Backpressure: result must hold and a pulsed operand must be ignored.
      bus8.out_ready = 1'b0;
      send(1'b0, 16'h005A, 16'h0033, 1'b1);
      wait_out8(k);
      check("bp_latency", 64'(k), 64'd9);
      for (int i = 0; i < 5; i++) begin
         bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55;
         check("bp_out_valid", 64'(bus8.out_valid), 64'd1);
         check("bp_sum", 64'(bus8.sum), 64'h8E);
         check("bp_cout", 64'(bus8.cout), 64'd0);
         check("bp_in_ready", 64'(bus8.in_ready), 64'd0);
         tick();
      end
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      tick();
      check("bp_in_ready_after", 64'(bus8.in_ready), 64'd1);
      check("bp_out_valid_after", 64'(bus8.out_valid), 64'd0);
      check("bp_sum_held", 64'(bus8.sum), 64'h8E);
      check("bp_no_extra_accept", 64'(q8.size()), 64'd0);

      // Reset in the 4th SHIFT cycle, then a clean operation.
      send(1'b0, 16'h0077, 16'h0011, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready", 64'(bus8.in_ready), 64'd1);
      check("abort_out_valid", 64'(bus8.out_valid), 64'd0);
      check("abort_sum", 64'(bus8.sum), 64'd0);
      check("abort_cout", 64'(bus8.cout), 64'd0);
      q8.delete();
`ifdef SERIAL_ADDER_OVF_EN
      check("abort_ovf", 64'(bus8.ovf), 64'd0);
      q8o.delete();
`endif
      tick();
      rst = 1'b0;
      tick();
      send(1'b0, 16'h0010, 16'h0020, 1'b0);
      wait_out8(k);
      check("post_abort_latency", 64'(k), 64'd9);
      check("post_abort_sum", 64'(bus8.sum), 64'h30);
      check("post_abort_cout", 64'(bus8.cout), 64'd0);
      tick();

      // Random sweeps with input gaps and random out_ready.
      rnd_en = 1'b1;
      base = n_out8;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(1'b0, 16'($urandom()), 16'($urandom()), 1'($urandom()));
      end
      g = 0;
      while ((q8.size() != 0 || bus8.out_valid) && g < 500) begin
         tick();
         g++;
      end
      check("sweep8_count", 64'(n_out8 - base), 64'd1000);
      check("sweep8_drained", 64'(q8.size()), 64'd0);

      base = n_out16;
      for (int i = 0; i < 1000; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()));
      end
      g = 0;
      while ((q16.size() != 0 || bus16.out_valid) && g < 500) begin
         tick();
         g++;
      end
      check("sweep16_count", 64'(n_out16 - base), 64'd1000);
      check("sweep16_drained", 64'(q16.size()), 64'd0);
      rnd_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
